// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - round-robin arbiter/sequencer sharing one single-port memory between cores
//
// Purpose:
//   Serialises LOAD/STORE requests from NUM_CORES cores onto one single-port
//   data memory. A requester is picked round-robin in IDLE, granted for one
//   ACCESS cycle, waits MEM_LAT cycles for read data on loads, and gets a
//   one-cycle done pulse in RESP.
//
// Optional feature macro: SHARED_MEM_ARB_LOCK_EN
//   Adds the lock input. A core whose lock bit is high in its RESP cycle keeps
//   priority for the next arbitration (atomic read-modify-write support).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   req        per-core request, held until gnt
//   we         per-core 1=STORE 0=LOAD
//   addr       per-core address, core i at [i*ADDR_W +: ADDR_W]
//   wdata      per-core store data, core i at [i*DATA_W +: DATA_W]
//   lock       per-core lock (only with SHARED_MEM_ARB_LOCK_EN)
//   gnt        one-cycle grant pulse (ACCESS cycle)
//   done       one-cycle completion pulse (RESP cycle)
//   rdata      per-core registered load result
//   busy       high whenever not IDLE
//   mem_en     memory strobe, ACCESS only
//   mem_we     memory write enable
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid MEM_LAT cycles after mem_en

module shared_mem_arbiter #(
    parameter int NUM_CORES = 3,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int MEM_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
`ifdef SHARED_MEM_ARB_LOCK_EN
    input  logic [NUM_CORES-1:0]        lock,
`endif
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        done,
    output logic [NUM_CORES*DATA_W-1:0] rdata,
    output logic                        busy,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]            sel_q, sel_d;
    logic                        we_q, we_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [DATA_W-1:0]           wdata_q, wdata_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_CORES*DATA_W-1:0] rdata_q, rdata_d;

    logic [PTR_W-1:0]            pick;
    logic                        pick_vld;
    int                          scan_idx;
    logic [PTR_W-1:0]            sel_inc;

    // Round-robin pick: first set req scanning upward from rr_ptr with wrap.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_CORES;
            if (!pick_vld && req[PTR_W'(scan_idx)]) begin
                pick     = PTR_W'(scan_idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign sel_inc = (sel_q == PTR_W'(NUM_CORES - 1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        sel_d     = sel_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        gnt       = '0;
        done      = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // The access is committed here; later input changes are ignored.
                if (pick_vld) begin
                    sel_d   = pick;
                    we_d    = we[pick];
                    addr_d  = addr[int'(pick)*ADDR_W +: ADDR_W];
                    wdata_d = wdata[int'(pick)*DATA_W +: DATA_W];
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                gnt[sel_q] = 1'b1;
                mem_en     = 1'b1;
                mem_we     = we_q;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                rr_ptr_d   = sel_inc;
                cnt_d      = '0;
                state_d    = we_q ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    rdata_d[int'(sel_q)*DATA_W +: DATA_W] = mem_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                done[sel_q] = 1'b1;
`ifdef SHARED_MEM_ARB_LOCK_EN
                // Pull the pointer back so a locked core wins the next IDLE scan.
                if (lock[sel_q]) begin
                    rr_ptr_d = sel_q;
                end
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port data memory between NUM_CORES processor cores for LOAD/STORE.
- Sits between the per-core load/store units and the shared memory inside the multicore top.
- Each core issues one request at a time.
- The arbiter serialises accesses, drives the memory port, and returns a completion pulse plus read data to the granted core.

Parameters:
- NUM_CORES, 3, number of requesting cores (2..8).
- ADDR_W, 12, memory address width.
- DATA_W, 8, memory data width.
- MEM_LAT, 1, read latency of the memory in cycles (>=1), counted from the mem_en cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: synchronous, active-low.
- req  in  NUM_CORES  per-core access request; held until the matching gnt.
- we  in  NUM_CORES  per-core 1=STORE, 0=LOAD.
- addr  in  NUM_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CORES*DATA_W  per-core store data.
- gnt  out  NUM_CORES  one-cycle grant pulse; core may drop req afterwards.
- done  out  NUM_CORES  one-cycle completion pulse.
- rdata  out  NUM_CORES*DATA_W  per-core load result; registered, held until that core's next load completes.
- busy  out  1  high in any state other than IDLE.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata all 0.
  - Reset mid-operation aborts the access: no gnt/done is issued for it and rdata is cleared.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If req!=0, select a core by round-robin: the first set req[i] scanning from rr_ptr upward, wrapping modulo NUM_CORES.
  - Latch sel, we[sel], addr[sel] and wdata[sel]; go to ACCESS.
  - If req=0, stay in IDLE.
- ACCESS (exactly one cycle):
  - mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values.
  - gnt[sel]=1.
  - rr_ptr <= (sel+1) mod NUM_CORES.
  - Next state: RESP for a write, WAIT for a read.
- WAIT: lasts exactly MEM_LAT cycles; mem_rdata is captured into rdata[sel] on the last WAIT cycle; then go to RESP.
- RESP (one cycle): done[sel]=1; next state IDLE.
- Latency from req sampled in IDLE:
  - Write: gnt at +1, done at +2.
  - Read: gnt at +1, done at +2+MEM_LAT; rdata valid in the done cycle.
- Throughput: one access per 3 cycles (write) or 3+MEM_LAT cycles (read). No new request is arbitrated until back in IDLE.
- Sampling and commitment:
  - Requests are sampled only in IDLE.
  - Input changes after the IDLE sample do not affect the in-flight access.
  - A req dropped before its gnt is ignored only if it was not yet sampled.
- Simultaneous requests: resolved strictly round-robin. With all cores requesting continuously, grants rotate 0,1,2,0,...
- A core that keeps req high after its done is re-arbitrated normally; it does not get back-to-back priority.
- Outputs not belonging to sel stay 0. The mem_* outputs are 0 outside ACCESS.

Optional Feature:
- Macro SHARED_MEM_ARB_LOCK_EN.
- When defined:
  - Adds input lock (NUM_CORES bits).
  - If lock[sel]=1 in the RESP cycle, rr_ptr is set to sel instead of advancing.
  - If req[sel] is high in the following IDLE, sel is granted again ahead of other requesters. This supports atomic read-modify-write.
  - Lock has no effect if the locked core does not request in that IDLE cycle.
- When undefined: no lock port; pure round-robin as above.

Test Plan:
1. Reset then single STORE: core0 req=1, we=1, addr=12'h011, wdata=8'hFE -> gnt[0] at +1 with mem_en=1, mem_we=1, mem_addr=12'h011, mem_wdata=8'hFE; done[0] at +2.
2. LOAD after store (memory model MEM_LAT=1): core0 we=0, addr=12'h011 -> done[0] at +3, rdata[0]=8'hFE; rdata[1] and rdata[2] remain 0.
3. All three cores request in the same cycle (stores to 12'h100, 12'h101, 12'h102) -> grants in order 0,1,2, each done before the next gnt; rr_ptr returns to 0.
4. Fairness: core2 holds req continuously and core0 requests once -> with rr_ptr=2, core2 is granted, then core0, then core2.
5. Reset mid-read: assert rst=0 during WAIT -> next cycle all outputs 0, no done pulse; after release, a new req[1] is granted first from rr_ptr=0.
6. With SHARED_MEM_ARB_LOCK_EN: core1 load with lock[1]=1 while core2 is requesting, followed by a core1 store -> core1 is granted twice consecutively before core2.
